uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: input synchroniser, control FSM and datapath in one block.
//  Configurable oversampling, data width, stop bits and optional parity.
//  Samples the serial line at mid-bit and delivers each frame as a one-cycle rx_valid strobe.
//  Reports framing and parity errors.
//  Sits between the pad-level rx line and the LFSR/command logic.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per bit; >=4
//  DATA_BITS     8   data bits per frame, 5..9, sent LSB first
//  STOP_BITS     1   stop bits, 1 or 2
//  PARITY_ODD    0   1 = odd, 0 = even; used only with UART_RX_PARITY_EN
// PORTS
//  clk         in   1          system clock
//  reset       in   1          synchronous, active-high
//  rx          in   1          asynchronous serial line, idle high
//  rx_byte     out  DATA_BITS  received data; held until the next frame completes
//  rx_valid    out  1          one-cycle strobe: frame complete, rx_byte/errors valid
//  frame_err   out  1          a stop-bit sample was 0; qualified by rx_valid
//  parity_err  out  1          parity mismatch; qualified by rx_valid
//  busy        out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset (synchronous, wins over everything, legal mid-frame):
//   state=IDLE; counters=0; sync flops=1; rx_byte=0; rx_valid=frame_err=parity_err=busy=0.
//  Synchroniser: rx passes through 2 flops to give rx_sync.
//  Derived constants: HALF=(CLKS_PER_BIT-1)/2; clk_cnt width = $clog2(CLKS_PER_BIT).
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> DONE -> IDLE|WAIT_HIGH.
//  IDLE:
//   - rx_sync==0 -> START with clk_cnt=0.
//  START:
//   - Count to HALF, then sample.
//   - Sample 0 -> DATA, clk_cnt=0, bit_idx=0.
//   - Sample 1 -> IDLE (glitch; no strobe).
//  DATA:
//   - Sample when clk_cnt==CLKS_PER_BIT-1, then clear clk_cnt.
//   - Shift the sample into the MSB of the shift register (right shift); bit_idx++.
//   - After DATA_BITS samples -> PARITY if compiled in, else STOP.
//  PARITY:
//   - One sample at full bit width.
//   - perr = (XOR of data ^ sample) != PARITY_ODD.
//  STOP:
//   - STOP_BITS samples at full bit width.
//   - Any 0 sample sets ferr.
//  DONE (1 cycle):
//   - rx_valid=1; rx_byte<=shift register; frame_err<=ferr; parity_err<=perr.
//   - Next state is WAIT_HIGH if ferr, else IDLE.
//  WAIT_HIGH:
//   - Stay until rx_sync==1, then IDLE. A break/stuck-low line gives one errored strobe, not repeats.
//  Latency:
//   - Reference edge e0 is the first clk edge that samples rx low into the first sync flop.
//   - rx_valid is high in the cycle after edge e0 + 3 + HALF + CLKS_PER_BIT*(DATA_BITS+P+STOP_BITS).
//   - P=1 if parity is compiled in, else 0.
//  rx_valid is never high on two consecutive cycles.
//  frame_err/parity_err hold their value until the next DONE.
//  rx_sync is not sampled in DONE. A falling edge in DONE is seen on the next IDLE cycle.
// CONFIGURATION
//  UART_RX_PARITY_EN:
//   - Defined: PARITY state present; P=1; parity_err is driven as above.
//   - Undefined: PARITY state and parity logic absent; P=0; parity_err tied 0; PARITY_ODD ignored.
// STRUCTURE
//  uart_pkg holds:
//   - State encodings: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH (3 bits).
//   - Parity-mode constants PAR_EVEN=0, PAR_ODD=1.
//   - A clog2 helper function.
//  One natural sub-module: uart_rx_sync (2-flop synchroniser, reset value 1).
//  FSM and datapath (clk_cnt, bit_idx, shift register, error latches) stay in this module.
// TESTING (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless noted)
//  1. Frame 0xA5, no parity -> rx_byte=8'hA5, errors 0, rx_valid at e0+154, width exactly 1 cycle.
//  2. rx low for 4 cycles, then high -> no rx_valid; busy returns to 0 within HALF+4 cycles.
//  3. Frame 0x3C, stop bit 0, then line high -> rx_valid, rx_byte=8'h3C, frame_err=1; next 0x55 frame -> frame_err=0.
//  4. rx held low for 40 bit times -> exactly one rx_valid (rx_byte=0, frame_err=1); no strobe until rx returns high.
//  5. UART_RX_PARITY_EN, PARITY_ODD=0, byte 0x07 (three ones):
//     - parity bit 1 -> parity_err=0;
//     - parity bit 0 -> parity_err=1;
//     - rx_valid at e0+170.
//  6. reset pulsed mid-DATA of a 0xFF frame -> all outputs 0 next cycle; a following 0x81 frame is received correctly.
//     Also rerun test 1 with DATA_BITS=7, STOP_BITS=2 -> 0x25 received, rx_valid at e0+154.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   state_t   : receiver FSM encoding (3 bits)
//   PAR_EVEN / PAR_ODD : parity-mode values for the PARITY_ODD parameter
//   clog2     : ceiling log2, usable in constant expressions
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    DONE      = 3'd5,
    WAIT_HIGH = 3'd6
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
//   clk     : system clock
//   reset   : synchronous, active-high; both flops reset to 1 (line idle)
//   rx      : asynchronous serial input
//   rx_sync : synchronised copy of rx, two clk cycles late
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_sync
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      meta    <= rx;
      rx_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, control FSM and datapath.
// Samples each bit at mid-bit and delivers a frame as a one-cycle rx_valid
// strobe together with framing and parity error flags.
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data).
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high, legal mid-frame
//   rx         : asynchronous serial line, idle high
//   rx_byte    : received data, held until the next frame completes
//   rx_valid   : one-cycle strobe, frame complete
//   frame_err  : a stop-bit sample was 0 (qualified by rx_valid)
//   parity_err : parity mismatch (qualified by rx_valid; 0 without parity)
//   busy       : FSM not in IDLE
//
// Handshake: rx_valid is a pure strobe with no back-pressure; rx_byte,
// frame_err and parity_err change only in the cycle rx_valid is high and
// hold until the next strobe.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = clog2(CLKS_PER_BIT);
  localparam int IW   = clog2(DATA_BITS + 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD)) begin : g_bad_params
    $error("uart_rx_param: illegal parameter set");
  end

  logic rx_sync;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_sync (rx_sync)
  );

  state_t               state, state_next;
  logic [CW-1:0]        clk_cnt, clk_cnt_next;
  logic [IW-1:0]        bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 ferr, ferr_next;
  logic [DATA_BITS-1:0] rx_byte_next;
  logic                 rx_valid_next;
  logic                 frame_err_next;
  logic                 bit_tick;

`ifdef UART_RX_PARITY_EN
  logic perr, perr_next;
  logic parity_err_next;
`endif

  assign bit_tick = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      ferr      <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      shreg     <= shreg_next;
      ferr      <= ferr_next;
      rx_byte   <= rx_byte_next;
      rx_valid  <= rx_valid_next;
      frame_err <= frame_err_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perr       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      perr       <= perr_next;
      parity_err <= parity_err_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    clk_cnt_next   = clk_cnt;
    bit_idx_next   = bit_idx;
    shreg_next     = shreg;
    ferr_next      = ferr;
    rx_byte_next   = rx_byte;
    rx_valid_next  = 1'b0;
    frame_err_next = frame_err;
`ifdef UART_RX_PARITY_EN
    perr_next       = perr;
    parity_err_next = parity_err;
`endif

    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_next   = START;
          clk_cnt_next = '0;
        end
      end

      START: begin
        if (clk_cnt == CW'(HALF)) begin
          if (!rx_sync) begin
            state_next   = DATA;
            clk_cnt_next = '0;
            bit_idx_next = '0;
            ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_next    = 1'b0;
`endif
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

      DATA: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shreg_next   = {rx_sync, shreg[DATA_BITS-1:1]};
          bit_idx_next = bit_idx + IW'(1);
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          perr_next    = ((^shreg) ^ rx_sync) != PARITY_ODD[0];
          state_next   = STOP;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
`endif

      STOP: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          bit_idx_next = bit_idx + IW'(1);
          if (!rx_sync) ferr_next = 1'b1;
          if (bit_idx == IW'(STOP_BITS - 1)) begin
            // Outputs are loaded on entry to DONE so that rx_valid and the
            // new data/error values are visible during the DONE cycle.
            state_next     = DONE;
            rx_valid_next  = 1'b1;
            rx_byte_next   = shreg;
            frame_err_next = ferr | ~rx_sync;
`ifdef UART_RX_PARITY_EN
            parity_err_next = perr;
`endif
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

      DONE: begin
        // A frame error usually means a break; wait for the line to go high
        // so a stuck-low line yields a single errored frame.
        state_next   = ferr ? WAIT_HIGH : IDLE;
        bit_idx_next = '0;
      end

      WAIT_HIGH: begin
        if (rx_sync) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param. Two instances: 8N1 (main) and
// 7 data bits / 2 stop bits. Parity frames are exercised when the bench is
// built with UART_RX_PARITY_EN.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int W = 27;  // {cycle[15:0], perr, ferr, data[8:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic rx2 = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rx_byte;
  logic       rx_valid, frame_err, parity_err, busy;
  logic [6:0] rx_byte2;
  logic       rx_valid2, frame_err2, parity_err2, busy2;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .rx_byte(rx_byte2), .rx_valid(rx_valid2),
    .frame_err(frame_err2), .parity_err(parity_err2), .busy(busy2)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q2[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic pend_a = 1'b0;
  logic pend_b = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (pend_a) begin
      check("a_valid_width", {31'd0, rx_valid}, 32'd0);
      pend_a = 1'b0;
    end else if (rx_valid) begin
      pend_a = 1'b1;
      check("a_valid_expected", {31'd0, rx_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("a_rx_byte",     {24'd0, rx_byte}, {23'd0, e[8:0]});
        check("a_frame_err",   {31'd0, frame_err}, {31'd0, e[9]});
        check("a_parity_err",  {31'd0, parity_err}, {31'd0, e[10]});
        check("a_valid_cycle", cyc, {16'd0, e[26:11]});
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (pend_b) begin
      check("b_valid_width", {31'd0, rx_valid2}, 32'd0);
      pend_b = 1'b0;
    end else if (rx_valid2) begin
      pend_b = 1'b1;
      check("b_valid_expected", {31'd0, rx_valid2}, {31'd0, exp_q2.size() != 0});
      if (exp_q2.size() != 0) begin
        e = exp_q2.pop_front();
        check("b_rx_byte",     {25'd0, rx_byte2}, {23'd0, e[8:0]});
        check("b_frame_err",   {31'd0, frame_err2}, {31'd0, e[9]});
        check("b_parity_err",  {31'd0, parity_err2}, {31'd0, e[10]});
        check("b_valid_cycle", cyc, {16'd0, e[26:11]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end on a falling edge.
  task automatic hold(input int which, input logic val, input int n);
    if (which == 0) rx = val; else rx2 = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int nstop, input logic stop_val, input logic par_flip);
    int   e0;
    logic par;
    logic [W-1:0] ent;
    e0  = cyc + 1;  // next rising edge captures the start bit
    par = par_flip;
    for (int i = 0; i < nbits; i++) par = par ^ data[i];
    ent = {16'(e0 + 3 + HALF + CPB * (nbits + P + nstop)),
           (P == 1) ? par_flip : 1'b0, ~stop_val, data};
    if (which == 0) exp_q.push_back(ent); else exp_q2.push_back(ent);
    hold(which, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) hold(which, data[i], CPB);
    if (P == 1) hold(which, par, CPB);
    for (int i = 0; i < nstop; i++) hold(which, stop_val, CPB);
    hold(which, 1'b1, 2 * CPB);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() + exp_q2.size()) != 0; i++) @(negedge clk);
    check("drain", exp_q.size() + exp_q2.size(), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_byte"},    {24'd0, rx_byte}, 32'd0);
    check({tag, "_rx_valid"},   {31'd0, rx_valid}, 32'd0);
    check({tag, "_frame_err"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_busy"},       {31'd0, busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0;
    logic [7:0] rb;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    hold(0, 1'b1, 4);

    // 1: basic frame, 8N1
    send_frame(0, 9'h0A5, 8, 1, 1'b1, 1'b0);
    drain();

    // 2: short low glitch on the line
    hold(0, 1'b0, 4);
    hold(0, 1'b1, HALF + 4);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    hold(0, 1'b1, CPB);

    // 3: framing error then a clean frame
    send_frame(0, 9'h03C, 8, 1, 1'b0, 1'b0);
    drain();
    send_frame(0, 9'h055, 8, 1, 1'b1, 1'b0);
    drain();

    // 4: line stuck low for 40 bit times
    e0 = cyc + 1;
    exp_q.push_back({16'(e0 + 3 + HALF + CPB * (8 + P + 1)), 1'b0, 1'b1, 9'h000});
    hold(0, 1'b0, 40 * CPB);
    drain();
    check("break_busy_low", {31'd0, busy}, 32'd1);
    hold(0, 1'b1, 4);
    check("break_busy_idle", {31'd0, busy}, 32'd0);
    hold(0, 1'b1, CPB);

`ifdef UART_RX_PARITY_EN
    // 5: parity, even mode, 0x07 has three ones
    send_frame(0, 9'h007, 8, 1, 1'b1, 1'b0);
    send_frame(0, 9'h007, 8, 1, 1'b1, 1'b1);
    drain();
`endif

    // 6: reset in the middle of a 0xFF frame
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, 40);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    reset = 1'b0;
    hold(0, 1'b1, CPB * 10);
    send_frame(0, 9'h081, 8, 1, 1'b1, 1'b0);
    drain();

    // 7 data bits, 2 stop bits
    send_frame(1, 9'h025, 7, 2, 1'b1, 1'b0);
    drain();

    // a few random bytes, back to back
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(0, {1'b0, rb}, 8, 1, 1'b1, 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
